booth_pp_reduce: RTL and testbench

- Pipelined reduction stage that consumes the 16 radix-4 Booth partial products of a 32x32 signed multiply.
- Partial products are 65-bit, already shifted by 2*i and sign-extended.
- Compresses them with a 3:2 carry-save tree, then a carry-propagate add, to give the 64-bit signed product.
- Sits directly downstream of the Booth partial-product generator in the RISC-V PE multiply unit; valid/ready handshake with a global-stall pipeline.

---
 rtl/mul_pkg.sv | 12 +
 rtl/csa_3to2.sv | 21 ++
 rtl/booth_pp_reduce.sv | 177 +++++++++++++++++
 tb/tb_booth_pp_reduce.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared multiply-unit constants and types, used by the Booth partial-product
// generator and the booth_pp_reduce carry-save reduction stage.
package mul_pkg;

  localparam int NUM_PP = 16;
  localparam int PP_W   = 65;
  localparam int PROD_W = 64;

  typedef logic signed [PP_W-1:0]   pp_t;
  typedef logic signed [PROD_W-1:0] prod_t;

endpackage

// File: rtl/csa_3to2.sv
// 3:2 carry-save compressor: three W-bit operands become a sum vector and a
// left-shifted carry vector. The carry out of the top bit is dropped (mod 2^W).
module csa_3to2 #(
  parameter int W = 65
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  output logic [W-1:0] o_sum,
  output logic [W-1:0] o_carry
);

  logic [W-1:0] w_maj;
  logic         w_unused_top;

  assign w_maj        = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
  assign o_sum        = i_a ^ i_b ^ i_c;
  assign o_carry      = {w_maj[W-2:0], 1'b0};
  assign w_unused_top = w_maj[W-1];

endmodule

// File: rtl/booth_pp_reduce.sv
// Four-stage pipelined CSA tree + CPA summing 16 radix-4 Booth partial products
// into a 64-bit product. Optional macro BOOTH_PP_REDUCE_FLUSH_EN adds a flush port.
module booth_pp_reduce
  import mul_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef BOOTH_PP_REDUCE_FLUSH_EN
  input  logic               flush,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PP_W-1:0]    pp [NUM_PP-1:0],
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PROD_W-1:0]  product,
  output logic [TAG_W-1:0]   out_tag
);

  pp_t w_l1 [11];
  pp_t w_l2 [8];
  pp_t r_s1 [8];
  pp_t w_l3 [6];
  pp_t w_l4 [4];
  pp_t r_s2 [4];
  pp_t w_l5 [3];
  pp_t w_l6 [2];
  pp_t r_sum;
  pp_t r_carry;

  logic [PP_W-1:0]   w_cpa;
  logic              w_unused_msb;
  logic [PROD_W-1:0] r_product;

  logic [TAG_W-1:0] r_tag1, r_tag2, r_tag3, r_tag4;
  logic             r_v1, r_v2, r_v3, r_v4;

  logic w_advance;
  logic w_accept;
  logic w_flush;

  // Global stall: the whole pipe moves only when the output slot is free or draining.
  assign w_advance = ~r_v4 | out_ready;

`ifdef BOOTH_PP_REDUCE_FLUSH_EN
  assign w_flush  = flush;
  assign in_ready = w_advance & ~flush;
`else
  assign w_flush  = 1'b0;
  assign in_ready = w_advance;
`endif

  assign w_accept = in_valid & in_ready;

  // Stage 1 combinational: 16 -> 11 -> 8
  genvar g;
  for (g = 0; g < 5; g++) begin : g_l1
    csa_3to2 #(.W(PP_W)) u_csa (
      .i_a    (pp[3*g]),
      .i_b    (pp[3*g+1]),
      .i_c    (pp[3*g+2]),
      .o_sum  (w_l1[2*g]),
      .o_carry(w_l1[2*g+1])
    );
  end
  assign w_l1[10] = pp[15];

  for (g = 0; g < 3; g++) begin : g_l2
    csa_3to2 #(.W(PP_W)) u_csa (
      .i_a    (w_l1[3*g]),
      .i_b    (w_l1[3*g+1]),
      .i_c    (w_l1[3*g+2]),
      .o_sum  (w_l2[2*g]),
      .o_carry(w_l2[2*g+1])
    );
  end
  assign w_l2[6] = w_l1[9];
  assign w_l2[7] = w_l1[10];

  // Stage 2 combinational: 8 -> 6 -> 4
  for (g = 0; g < 2; g++) begin : g_l3
    csa_3to2 #(.W(PP_W)) u_csa (
      .i_a    (r_s1[3*g]),
      .i_b    (r_s1[3*g+1]),
      .i_c    (r_s1[3*g+2]),
      .o_sum  (w_l3[2*g]),
      .o_carry(w_l3[2*g+1])
    );
  end
  assign w_l3[4] = r_s1[6];
  assign w_l3[5] = r_s1[7];

  for (g = 0; g < 2; g++) begin : g_l4
    csa_3to2 #(.W(PP_W)) u_csa (
      .i_a    (w_l3[3*g]),
      .i_b    (w_l3[3*g+1]),
      .i_c    (w_l3[3*g+2]),
      .o_sum  (w_l4[2*g]),
      .o_carry(w_l4[2*g+1])
    );
  end

  // Stage 3 combinational: 4 -> 3 -> 2
  csa_3to2 #(.W(PP_W)) u_csa_l5 (
    .i_a    (r_s2[0]),
    .i_b    (r_s2[1]),
    .i_c    (r_s2[2]),
    .o_sum  (w_l5[0]),
    .o_carry(w_l5[1])
  );
  assign w_l5[2] = r_s2[3];

  csa_3to2 #(.W(PP_W)) u_csa_l6 (
    .i_a    (w_l5[0]),
    .i_b    (w_l5[1]),
    .i_c    (w_l5[2]),
    .o_sum  (w_l6[0]),
    .o_carry(w_l6[1])
  );

  // Stage 4 combinational: full-width CPA; only the low 64 bits form the product.
  assign w_cpa        = r_sum + r_carry;
  assign w_unused_msb = w_cpa[PP_W-1];

  // Valid bits: flush kills in-flight items even while stalled; reset dominates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      r_v4 <= 1'b0;
    end else if (w_flush) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      r_v4 <= 1'b0;
    end else if (w_advance) begin
      r_v1 <= w_accept;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      r_v4 <= r_v3;
    end
  end

  // Datapath and tags clock whenever the pipe advances, valid or not.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_s1[i] <= '0;
      for (int i = 0; i < 4; i++) r_s2[i] <= '0;
      r_sum     <= '0;
      r_carry   <= '0;
      r_product <= '0;
      r_tag1    <= '0;
      r_tag2    <= '0;
      r_tag3    <= '0;
      r_tag4    <= '0;
    end else if (w_advance) begin
      for (int i = 0; i < 8; i++) r_s1[i] <= w_l2[i];
      for (int i = 0; i < 4; i++) r_s2[i] <= w_l4[i];
      r_sum     <= w_l6[0];
      r_carry   <= w_l6[1];
      r_product <= w_cpa[PROD_W-1:0];
      r_tag1    <= in_tag;
      r_tag2    <= r_tag1;
      r_tag3    <= r_tag2;
      r_tag4    <= r_tag3;
    end
  end

  assign out_valid = r_v4;
  assign product   = r_product;
  assign out_tag   = r_tag4;

endmodule

// File: tb/tb_booth_pp_reduce.sv
// Self-checking bench for booth_pp_reduce: Booth-encodes A/B in the bench and
// compares every product against A*B. Define BOOTH_PP_REDUCE_FLUSH_EN for flush tests.
module tb_booth_pp_reduce;

  logic        clk = 1'b0;
  logic        rst_n;
`ifdef BOOTH_PP_REDUCE_FLUSH_EN
  logic        flush;
`endif
  logic        in_valid;
  logic        in_ready;
  logic [64:0] pp [15:0];
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;
  logic [4:0]  out_tag;

  always #5 clk = ~clk;

  booth_pp_reduce #(.TAG_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef BOOTH_PP_REDUCE_FLUSH_EN
    .flush    (flush),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pp       (pp),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product),
    .out_tag  (out_tag)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    logic [63:0] prod;
    logic [4:0]  tag;
  } exp_t;

  exp_t        expQ[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] lastProd;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Radix-4 Booth encoding of b, multiplicand a, each term shifted and sign-extended to 65 bits.
  task automatic setOperands(input logic [31:0] a, input logic [31:0] b);
    logic [32:0]        bx;
    logic [2:0]         bits;
    int                 d;
    logic signed [64:0] a65;
    logic signed [64:0] d65;
    logic signed [64:0] t;
    bx  = {b, 1'b0};
    a65 = {{33{a[31]}}, a};
    for (int i = 0; i < 16; i++) begin
      bits  = bx[2*i+2 -: 3];
      d     = -2 * int'(bits[2]) + int'(bits[1]) + int'(bits[0]);
      d65   = d;
      t     = a65 * d65;
      pp[i] = t << (2 * i);
    end
  endtask

  function automatic logic [63:0] refMul(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  // One clock of stimulus; outputs are checked #1 after the falling edge.
  task automatic applyStimulus(input bit iv, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] tag, input bit ordy,
                               output bit accepted, output bit gotOut);
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    setOperands(a, b);
    in_tag    = tag;
    out_ready = ordy;
    #1;
    gotOut = 1'b0;
    if (out_valid && out_ready) begin
      gotOut   = 1'b1;
      lastProd = product;
      if (expQ.size() == 0) begin
        checkOutput("spurious_out_valid", 64'(out_valid), 64'(0));
      end else begin
        e = expQ.pop_front();
        checkOutput("product", product, e.prod);
        checkOutput("out_tag", 64'(out_tag), 64'(e.tag));
      end
    end
    accepted = iv && in_ready;
    if (accepted) begin
      e.prod = refMul(a, b);
      e.tag  = tag;
      expQ.push_back(e);
    end
  endtask

  task automatic drain();
    bit acc, got;
    for (int i = 0; i < 20 && expQ.size() > 0; i++)
      applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 1'b1, acc, got);
    checkOutput("drain_empty", 64'(expQ.size()), 64'(0));
    expQ.delete();
  endtask

  task automatic runSingle(input vec_t v, input string name);
    bit acc, got;
    int lat;
    applyStimulus(1'b1, v.a, v.b, v.tag, 1'b1, acc, got);
    checkOutput({name, "_accept"}, 64'(acc), 64'(1));
    lat = 0;
    got = 1'b0;
    while (!got && lat < 10) begin
      applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 1'b1, acc, got);
      lat++;
    end
    checkOutput({name, "_latency"}, 64'(lat), 64'(4));
    checkOutput({name, "_value"}, lastProd, v.exp);
    expQ.delete();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t        vecs[6];
    bit          acc, got;
    int          outs, stalls, missed;
    logic [31:0] pa, pb;
    logic [4:0]  pt;

    vecs[0] = '{32'd3,        32'd5,        5'd7,  64'd15};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  64'd1};
    vecs[2] = '{32'h80000000, 32'h80000000, 5'd30, 64'h4000000000000000};
    vecs[3] = '{32'h7FFFFFFF, 32'h80000000, 5'd31, 64'hC000000080000000};
    vecs[4] = '{32'd0,        32'd12345,    5'd12, 64'd0};
    vecs[5] = '{32'd1,        32'hFFFFFFFF, 5'd19, 64'hFFFFFFFFFFFFFFFF};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_tag    = '0;
`ifdef BOOTH_PP_REDUCE_FLUSH_EN
    flush     = 1'b0;
`endif
    setOperands(32'd0, 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
    checkOutput("reset_product", product, 64'd0);
    checkOutput("reset_out_tag", 64'(out_tag), 64'(0));
    rst_n = 1'b1;
    #1;
    checkOutput("reset_in_ready", 64'(in_ready), 64'(1));

    $display("[TB] directed vectors");
    foreach (vecs[i]) runSingle(vecs[i], $sformatf("vec%0d", i));

    $display("[TB] back-to-back random burst");
    outs   = 0;
    missed = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, $urandom, $urandom, 5'($urandom_range(0, 31)), 1'b1, acc, got);
      if (!acc) missed++;
      if (got) outs++;
    end
    checkOutput("burst_in_ready_drops", 64'(missed), 64'(0));
    checkOutput("burst_outputs", 64'(outs), 64'(96));
    drain();

    $display("[TB] stall with full pipe");
    pa = $urandom; pb = $urandom; pt = 5'($urandom_range(0, 31));
    stalls = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, pa, pb, pt, 1'b0, acc, got);
      if (acc) begin
        pa = $urandom; pb = $urandom; pt = 5'($urandom_range(0, 31));
      end else begin
        stalls++;
        checkOutput("stall_out_valid", 64'(out_valid), 64'(1));
        if (expQ.size() > 0) begin
          checkOutput("stall_product", product, expQ[0].prod);
          checkOutput("stall_out_tag", 64'(out_tag), 64'(expQ[0].tag));
        end
      end
    end
    checkOutput("stall_cycles", 64'(stalls), 64'(6));
    checkOutput("stall_held_items", 64'(expQ.size()), 64'(4));
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, pa, pb, pt, 1'b1, acc, got);
      if (acc) begin
        pa = $urandom; pb = $urandom; pt = 5'($urandom_range(0, 31));
      end
    end
    drain();

    $display("[TB] reset with items in flight");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, $urandom | 32'h1, $urandom | 32'h1, 5'($urandom_range(0, 31)), 1'b1, acc, got);
    applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, acc, got);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("midreset_out_valid", 64'(out_valid), 64'(0));
    checkOutput("midreset_product", product, 64'd0);
    checkOutput("midreset_in_ready", 64'(in_ready), 64'(1));
    expQ.delete();
    outs = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 1'b1, acc, got);
      if (got) outs++;
    end
    checkOutput("midreset_stale_outputs", 64'(outs), 64'(0));
    runSingle('{32'hFFFFFFF9, 32'd11, 5'd4, 64'hFFFFFFFFFFFFFFB3}, "post_reset");

`ifdef BOOTH_PP_REDUCE_FLUSH_EN
    $display("[TB] flush with full pipe");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, $urandom, $urandom, 5'($urandom_range(0, 31)), 1'b0, acc, got);
    checkOutput("flush_items_loaded", 64'(expQ.size()), 64'(4));
    @(negedge clk);
    flush     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    setOperands(32'd9, 32'd9);
    #1;
    checkOutput("flush_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("flush_out_valid", 64'(out_valid), 64'(0));
    expQ.delete();
    runSingle('{32'd7, 32'd6, 5'd9, 64'd42}, "post_flush");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
